// File: rtl/key_entry.sv
// Keypad-to-expression entry: builds packed-BCD operands A/B plus operator, hands off on "=".
// Optional key echo port is built when KEY_ENTRY_ECHO_EN is defined.
module key_entry #(
  parameter int DIGITS         = 4,
  parameter int RELEASE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            num,
  input  logic                  key_pressed,
  output logic [4*DIGITS-1:0]   op_a,
  output logic [4*DIGITS-1:0]   op_b,
  output logic [1:0]            op_code,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   disp_bcd,
  output logic                  ovf
`ifdef KEY_ENTRY_ECHO_EN
  ,
  output logic                  echo_valid,
  output logic [3:0]            echo_code
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int RW = $clog2(RELEASE_CYCLES + 1);
  localparam logic [CW-1:0] DIG_MAX  = CW'(DIGITS);
  localparam logic [RW-1:0] REL_LAST = RW'(RELEASE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_A    = 2'd0,
    ST_B    = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt_a, cnt_a_n;
  logic [CW-1:0]   cnt_b, cnt_b_n;
  logic [RW-1:0]   rel_cnt, rel_cnt_n;
  logic            armed, armed_n;
  logic [W-1:0]    op_a_n, op_b_n, disp_n;
  logic [1:0]      op_code_n;
  logic            out_valid_n, ovf_n;

  logic            key_ev;
  logic            is_digit, is_op, is_eq, is_clr;
  logic [1:0]      key_op;

  assign key_ev   = key_pressed & armed;
  assign is_digit = (num <= 4'd9);
  assign is_op    = (num >= 4'd10) && (num <= 4'd13);
  assign is_eq    = (num == 4'd14);
  assign is_clr   = (num == 4'd15);
  // A..D are 1010,1011,1100,1101: bits [2] and [0] give the operator index directly
  assign key_op   = {num[2], num[0]};

  // Next-state: release debounce, entry state machine and display selection
  always_comb begin
    state_n     = state;
    cnt_a_n     = cnt_a;
    cnt_b_n     = cnt_b;
    rel_cnt_n   = rel_cnt;
    armed_n     = armed;
    op_a_n      = op_a;
    op_b_n      = op_b;
    op_code_n   = op_code;
    out_valid_n = out_valid;
    ovf_n       = 1'b0;
    disp_n      = {W{1'b0}};

    if (key_ev) begin
      armed_n   = 1'b0;
      rel_cnt_n = {RW{1'b0}};
    end else if (key_pressed) begin
      rel_cnt_n = {RW{1'b0}};
    end else if (!armed) begin
      if (rel_cnt == REL_LAST) begin
        armed_n   = 1'b1;
        rel_cnt_n = {RW{1'b0}};
      end else begin
        rel_cnt_n = rel_cnt + RW'(1);
      end
    end else begin
      rel_cnt_n = {RW{1'b0}};
    end

    case (state)
      ST_A: begin
        if (key_ev && is_digit) begin
          if (cnt_a < DIG_MAX) begin
            op_a_n  = {op_a[W-5:0], num};
            cnt_a_n = cnt_a + CW'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end else if (key_ev && is_op) begin
          if (cnt_a != {CW{1'b0}}) begin
            op_code_n = key_op;
            state_n   = ST_B;
          end else begin
            state_n = ST_A;
          end
        end else if (key_ev && is_clr) begin
          op_a_n  = {W{1'b0}};
          cnt_a_n = {CW{1'b0}};
        end else begin
          state_n = ST_A;
        end
      end
      ST_B: begin
        if (key_ev && is_digit) begin
          if (cnt_b < DIG_MAX) begin
            op_b_n  = {op_b[W-5:0], num};
            cnt_b_n = cnt_b + CW'(1);
          end else begin
            ovf_n = 1'b1;
          end
        end else if (key_ev && is_op) begin
          if (cnt_b == {CW{1'b0}}) begin
            op_code_n = key_op;
          end else begin
            op_code_n = op_code;
          end
        end else if (key_ev && is_eq) begin
          if (cnt_b != {CW{1'b0}}) begin
            state_n     = ST_SEND;
            out_valid_n = 1'b1;
          end else begin
            state_n = ST_B;
          end
        end else if (key_ev && is_clr) begin
          op_a_n    = {W{1'b0}};
          op_b_n    = {W{1'b0}};
          cnt_a_n   = {CW{1'b0}};
          cnt_b_n   = {CW{1'b0}};
          op_code_n = 2'd0;
          state_n   = ST_A;
        end else begin
          state_n = ST_B;
        end
      end
      ST_SEND: begin
        // key events here only disarm; the expression stays frozen until accepted
        if (out_valid && out_ready) begin
          op_a_n      = {W{1'b0}};
          op_b_n      = {W{1'b0}};
          cnt_a_n     = {CW{1'b0}};
          cnt_b_n     = {CW{1'b0}};
          op_code_n   = 2'd0;
          out_valid_n = 1'b0;
          state_n     = ST_A;
        end else begin
          state_n = ST_SEND;
        end
      end
      default: begin
        state_n     = ST_A;
        op_a_n      = {W{1'b0}};
        op_b_n      = {W{1'b0}};
        cnt_a_n     = {CW{1'b0}};
        cnt_b_n     = {CW{1'b0}};
        op_code_n   = 2'd0;
        out_valid_n = 1'b0;
      end
    endcase

    case (state_n)
      ST_A:    disp_n = op_a_n;
      ST_B:    disp_n = (cnt_b_n != {CW{1'b0}}) ? op_b_n : op_a_n;
      ST_SEND: disp_n = op_b_n;
      default: disp_n = {W{1'b0}};
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_A;
      cnt_a     <= {CW{1'b0}};
      cnt_b     <= {CW{1'b0}};
      rel_cnt   <= {RW{1'b0}};
      armed     <= 1'b1;
      op_a      <= {W{1'b0}};
      op_b      <= {W{1'b0}};
      op_code   <= 2'd0;
      out_valid <= 1'b0;
      disp_bcd  <= {W{1'b0}};
      ovf       <= 1'b0;
    end else begin
      state     <= state_n;
      cnt_a     <= cnt_a_n;
      cnt_b     <= cnt_b_n;
      rel_cnt   <= rel_cnt_n;
      armed     <= armed_n;
      op_a      <= op_a_n;
      op_b      <= op_b_n;
      op_code   <= op_code_n;
      out_valid <= out_valid_n;
      disp_bcd  <= disp_n;
      ovf       <= ovf_n;
    end
  end

`ifdef KEY_ENTRY_ECHO_EN
  // Echo every accepted key event one cycle later, whatever the state did with it
  always_ff @(posedge clk) begin
    if (reset) begin
      echo_valid <= 1'b0;
      echo_code  <= 4'd0;
    end else begin
      echo_valid <= key_ev;
      echo_code  <= key_ev ? num : 4'd0;
    end
  end
`endif

endmodule

// File: doc/key_entry.md
Name: key_entry

Overview:
- Sits directly downstream of the 4x4 keypad scanner. Consumes its `num` / `keyPressed` outputs and turns key presses into a calculator expression: operand A, operator, operand B.
- Operands are assembled as packed BCD.
- On "=" it presents the complete expression to the link/transmit stage over a valid/ready handshake.
- Also drives a BCD display bus showing the operand currently being entered.

Parameters:
- DIGITS, 4: maximum decimal digits per operand. Operand width is 4*DIGITS bits.
- RELEASE_CYCLES, 16: consecutive clk cycles with key_pressed low required before the next press is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- num  in  4  key code from the scanner, valid while key_pressed=1. The scanner outputs are already synchronised to clk by the top level.
- key_pressed  in  1  scanner key-down level.
- op_a  out  4*DIGITS  operand A, packed BCD, least-significant digit in [3:0].
- op_b  out  4*DIGITS  operand B, packed BCD.
- op_code  out  2  operator: 0=add, 1=sub, 2=mul, 3=div.
- out_valid  out  1  expression valid.
- out_ready  in  1  downstream accepts.
- disp_bcd  out  4*DIGITS  value for the display.
- ovf  out  1  one-cycle pulse when a digit is dropped because the operand is full.

Behaviour:
- Reset: all outputs 0, state ST_A, both digit counts 0, armed=1.
- Key event: key_pressed=1 while armed=1 produces exactly one event in that cycle, using num from that cycle.
  - armed clears on the event.
  - armed sets again after RELEASE_CYCLES consecutive cycles with key_pressed=0. Any high cycle restarts the release counter.
  - A held key yields exactly one event.
- Key map: 0-9 = digit; A=add, B=sub, C=mul, D=div (operator keys); E = equals; F = clear.
- ST_A:
  - Digit: if cnt_a<DIGITS then op_a <= {op_a[4*DIGITS-5:0], digit} and cnt_a++; otherwise the digit is dropped and ovf pulses.
  - Operator: if cnt_a>0, set op_code and go to ST_B; ignored if cnt_a=0.
  - Equals: ignored.
  - Clear: op_a, cnt_a <= 0.
- ST_B:
  - Digit: same shift and overflow rule applied to op_b / cnt_b.
  - Operator: if cnt_b=0, replaces op_code; otherwise ignored.
  - Equals: if cnt_b>0, go to ST_SEND and set out_valid=1 on the next cycle edge; otherwise ignored.
  - Clear: op_a, op_b, counts, op_code <= 0; go to ST_A.
- ST_SEND:
  - out_valid=1 and op_a, op_b, op_code held stable until out_valid&&out_ready.
  - On that handshake cycle: out_valid drops next cycle, all operands, counts and op_code clear, go to ST_A.
  - Key events in ST_SEND, including clear, are discarded, but they still disarm.
- out_valid never falls without a handshake, except on reset.
- disp_bcd:
  - ST_A: op_a.
  - ST_B: op_b if cnt_b>0, else op_a.
  - ST_SEND: op_b.
- Latency: every register update from a key event is visible on the edge after the event cycle (1 clk).
- Reset asserted mid-entry or in ST_SEND: everything returns to reset values on that edge; a pending expression is lost.
- Leading zeros count as digits ("0","0" gives cnt=2).

Optional Feature:
- Macro: KEY_ENTRY_ECHO_EN.
- Defined: adds output ports echo_valid (1) and echo_code (4). For every accepted key event in any state, echo_valid pulses for one cycle, 1 clk after the event, with echo_code=num. This includes dropped-overflow digits and events discarded in ST_SEND. Reset value 0/0.
- Undefined: the ports are absent and there is no related logic.

Test Plan:
- Reset, press 1,2 (hold each 5 cycles, release 20), A, 3, E with out_ready=1 → out_valid for one cycle with op_a=0x0012, op_b=0x0003, op_code=0, then all outputs 0.
- Hold key 7 high for 100 cycles → exactly one digit; op_a=0x0007.
- Press 7, release only 10 cycles (<16), press 8 → 8 ignored; op_a=0x0007.
- DIGITS=4: enter 1,2,3,4,5 → op_a=0x1234 and ovf pulses once on the 5.
- Enter 9, C, D, 4, E with out_ready=0 for 50 cycles → out_valid held at 1 with op_code=3; pressing F during the wait changes nothing; raising out_ready completes the transfer.
- Enter 5, A, 6, press F → op_a=op_b=0, state ST_A. Assert reset while in ST_SEND → out_valid=0 next edge.
